sh7604_intc_onchip: RTL and testbench

- On-chip peripheral interrupt controller for the SH7604 core.
- Arbitrates the module IRQ lines (DIVU, DMAC0/1, WDT, SCI ERI/RXI/TXI/TEI, FRT ICI/OCI/OVI) into one level plus vector toward the CPU interrupt sequencer.
- Holds the IPRA/IPRB priority registers and the VCRA..VCRD/VCRWDT vector registers on IBUS.
- Locks the winning vector across the CPU acknowledge handshake.

---
 rtl/sh7604_intc_onchip_if.sv | 26 ++
 rtl/sh7604_intc_onchip.sv | 244 ++++++++++++++++++++++++
 tb/tb_sh7604_intc_onchip.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sh7604_intc_onchip_if.sv
`default_nettype none
// ============================================================================
// Module      : sh7604_intc_onchip_if
// Description : IBUS register-access bundle for the SH7604 on-chip INTC.
//               The master drives the address, data, lanes and strobes.
//               The slave returns read data, BUSY and ACT.
//   A    [31:0] address          DI  [31:0] write data
//   BA   [3:0]  byte lanes       WE         write strobe
//   REQ         bus request      DO  [31:0] read data
//   BUSY        wait request     ACT        address hit
// Revision    : 1.0 - initial release
// ============================================================================
interface sh7604_intc_onchip_if;
  logic [31:0] A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic [3:0]  BA;
  logic        WE;
  logic        REQ;
  logic        BUSY;
  logic        ACT;

  modport master (output A, DI, BA, WE, REQ, input DO, BUSY, ACT);
  modport slave  (input A, DI, BA, WE, REQ, output DO, BUSY, ACT);
endinterface
`default_nettype wire

// File: rtl/sh7604_intc_onchip.sv
`default_nettype none
// ============================================================================
// Module      : sh7604_intc_onchip
// Description : On-chip peripheral interrupt controller. It holds the
//               IPRA/IPRB and VCRA..VCRD/VCRWDT registers on IBUS. It
//               arbitrates the 11 module IRQ lines into one level and one
//               vector for the CPU. It freezes the winner across the
//               acknowledge handshake.
// Ports       : CLK, RST_N (async, active low)
//               CE_R/CE_F   rising/falling phase enables
//               EN          arbitration enable
//               RES_N       sync chip reset
//               IBUS        register bus (slave modport)
//               SRC_IRQ[10:0], DMA0_VEC, DMA1_VEC, DIVU_VEC, INT_ACK
//               INT_LVL[3:0], INT_VEC[7:0], INT_ACK_SRC[10:0]
// Revision    : 1.0 - initial release
// ============================================================================
module sh7604_intc_onchip #(
  parameter int LOCK_CYC = 2
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CE_R,
  input  logic                       CE_F,
  input  logic                       EN,
  input  logic                       RES_N,
  sh7604_intc_onchip_if.slave        IBUS,
  input  logic [10:0]                SRC_IRQ,
  input  logic [7:0]                 DMA0_VEC,
  input  logic [7:0]                 DMA1_VEC,
  input  logic [7:0]                 DIVU_VEC,
  input  logic                       INT_ACK,
  output logic [3:0]                 INT_LVL,
  output logic [7:0]                 INT_VEC,
  output logic [10:0]                INT_ACK_SRC
);

  // Register file slots
  localparam logic [2:0] c_IPRB = 3'd0, c_VCRA = 3'd1, c_VCRB = 3'd2,
                         c_VCRC = 3'd3, c_VCRD = 3'd4, c_IPRA = 3'd5,
                         c_VCRW = 3'd6;
  localparam int c_CW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PEND = 2'd1, ST_LOCK = 2'd2} state_t;

  // Implemented bits per register. The other bits are never stored, so
  // they read back as 0.
  function automatic logic [15:0] f_mask(input logic [2:0] idx);
    case (idx)
      c_IPRB:  f_mask = 16'hFF00;
      c_IPRA:  f_mask = 16'hFFF0;
      c_VCRD,
      c_VCRW:  f_mask = 16'h7F00;
      default: f_mask = 16'h7F7F;
    endcase
  endfunction

  logic [15:0] r_regs [0:6];
  logic [15:0] r_reg_do;
  logic        w_hit;
  logic [2:0]  w_idx;
  logic [15:0] w_wd, w_old, w_wval;
  logic [1:0]  w_be;
  logic        w_wr;
  logic        w_unused_ok;

  // --------------------------------------------------------------------------
  // Address decode (halfword registers, so A[0] plays no role)
  // --------------------------------------------------------------------------
  always_comb begin
    w_hit = 1'b0;
    w_idx = c_IPRB;
    if (IBUS.A[31:8] == 24'hFFFFFE) begin
      case ({IBUS.A[7:1], 1'b0})
        8'h60: begin w_hit = 1'b1; w_idx = c_IPRB; end
        8'h62: begin w_hit = 1'b1; w_idx = c_VCRA; end
        8'h64: begin w_hit = 1'b1; w_idx = c_VCRB; end
        8'h66: begin w_hit = 1'b1; w_idx = c_VCRC; end
        8'h68: begin w_hit = 1'b1; w_idx = c_VCRD; end
        8'hE2: begin w_hit = 1'b1; w_idx = c_IPRA; end
        8'hE4: begin w_hit = 1'b1; w_idx = c_VCRW; end
        default: ;
      endcase
    end
  end

  assign w_unused_ok = &{1'b0, IBUS.A[0]};

  // A[1] selects the halfword lane. be[1] is the high byte of that lane.
  assign w_wd   = IBUS.A[1] ? IBUS.DI[15:0] : IBUS.DI[31:16];
  assign w_be   = IBUS.A[1] ? IBUS.BA[1:0]  : IBUS.BA[3:2];
  assign w_old  = r_regs[w_idx];
  assign w_wval = {w_be[1] ? w_wd[15:8] : w_old[15:8],
                   w_be[0] ? w_wd[7:0]  : w_old[7:0]} & f_mask(w_idx);
  assign w_wr   = IBUS.REQ & IBUS.WE & w_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 7; i++) r_regs[i] <= '0;
    end else if (CE_R) begin
      if (!RES_N) begin
        for (int i = 0; i < 7; i++) r_regs[i] <= '0;
      end else if (w_wr) begin
        r_regs[w_idx] <= w_wval;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_reg_do <= '0;
    else if (CE_F)
      r_reg_do <= (IBUS.REQ && !IBUS.WE && w_hit) ? r_regs[w_idx] : 16'h0000;
  end

  assign IBUS.DO   = (IBUS.REQ && w_hit) ? {r_reg_do, r_reg_do} : 32'h0;
  assign IBUS.BUSY = 1'b0;
  assign IBUS.ACT  = w_hit;

  // --------------------------------------------------------------------------
  // Per-source level/vector and the combinational arbiter
  // --------------------------------------------------------------------------
  logic [3:0]  w_src_lvl [0:10];
  logic [7:0]  w_src_vec [0:10];
  logic [3:0]  w_best_lvl;
  logic [7:0]  w_best_vec;
  logic [10:0] w_best_src;
  logic        w_any;

  assign w_src_lvl[10] = r_regs[c_IPRA][15:12];
  assign w_src_lvl[9]  = r_regs[c_IPRA][11:8];
  assign w_src_lvl[8]  = r_regs[c_IPRA][11:8];
  assign w_src_lvl[7]  = r_regs[c_IPRA][7:4];
  assign w_src_lvl[6]  = r_regs[c_IPRB][15:12];
  assign w_src_lvl[5]  = r_regs[c_IPRB][15:12];
  assign w_src_lvl[4]  = r_regs[c_IPRB][15:12];
  assign w_src_lvl[3]  = r_regs[c_IPRB][15:12];
  assign w_src_lvl[2]  = r_regs[c_IPRB][11:8];
  assign w_src_lvl[1]  = r_regs[c_IPRB][11:8];
  assign w_src_lvl[0]  = r_regs[c_IPRB][11:8];

  assign w_src_vec[10] = DIVU_VEC;
  assign w_src_vec[9]  = DMA0_VEC;
  assign w_src_vec[8]  = DMA1_VEC;
  assign w_src_vec[7]  = {1'b0, r_regs[c_VCRW][14:8]};
  assign w_src_vec[6]  = {1'b0, r_regs[c_VCRA][14:8]};
  assign w_src_vec[5]  = {1'b0, r_regs[c_VCRA][6:0]};
  assign w_src_vec[4]  = {1'b0, r_regs[c_VCRB][14:8]};
  assign w_src_vec[3]  = {1'b0, r_regs[c_VCRB][6:0]};
  assign w_src_vec[2]  = {1'b0, r_regs[c_VCRC][14:8]};
  assign w_src_vec[1]  = {1'b0, r_regs[c_VCRC][6:0]};
  assign w_src_vec[0]  = {1'b0, r_regs[c_VCRD][14:8]};

  // The scan runs upward with >=, so on equal levels the higher index wins.
  always_comb begin
    w_best_lvl = 4'd0;
    w_best_vec = 8'd0;
    w_best_src = 11'd0;
    for (int i = 0; i < 11; i++) begin
      if (SRC_IRQ[i] && (w_src_lvl[i] != 4'd0) && (w_src_lvl[i] >= w_best_lvl)) begin
        w_best_lvl = w_src_lvl[i];
        w_best_vec = w_src_vec[i];
        w_best_src = 11'(1) << i;
      end
    end
    w_any = (w_best_lvl != 4'd0);
  end

  // --------------------------------------------------------------------------
  // Request/acknowledge FSM
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [3:0]  r_lvl;
  logic [7:0]  r_vec;
  logic [10:0] r_src;
  logic [10:0] r_ack_src;
  logic [c_CW-1:0] r_lock_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_lvl      <= '0;
      r_vec      <= '0;
      r_src      <= '0;
      r_ack_src  <= '0;
      r_lock_cnt <= '0;
    end else if (CE_R) begin
      r_ack_src <= '0;
      if (!RES_N) begin
        r_state    <= ST_IDLE;
        r_lvl      <= '0;
        r_vec      <= '0;
        r_src      <= '0;
        r_lock_cnt <= '0;
      end else if (EN) begin
        case (r_state)
          ST_IDLE: begin
            if (w_any) begin
              r_lvl   <= w_best_lvl;
              r_vec   <= w_best_vec;
              r_src   <= w_best_src;
              r_state <= ST_PEND;
            end
          end
          ST_PEND: begin
            if (INT_ACK) begin
              // Acknowledge the source the CPU actually saw, not the
              // winner of this cycle.
              r_ack_src  <= r_src;
              r_lock_cnt <= c_CW'(LOCK_CYC - 1);
              r_state    <= ST_LOCK;
            end else if (w_any) begin
              r_lvl <= w_best_lvl;
              r_vec <= w_best_vec;
              r_src <= w_best_src;
            end else begin
              r_lvl   <= '0;
              r_vec   <= '0;
              r_src   <= '0;
              r_state <= ST_IDLE;
            end
          end
          ST_LOCK: begin
            if (r_lock_cnt == '0) begin
              r_lvl   <= '0;
              r_vec   <= '0;
              r_src   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_lock_cnt <= r_lock_cnt - 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign INT_LVL     = r_lvl;
  assign INT_VEC     = r_vec;
  assign INT_ACK_SRC = r_ack_src;

endmodule
`default_nettype wire

// File: tb/tb_sh7604_intc_onchip.sv
`default_nettype none
// ============================================================================
// Module      : tb_sh7604_intc_onchip
// Description : Directed self-checking bench for sh7604_intc_onchip.
//               Inputs change just after a falling edge. Outputs are
//               sampled at the following falling edge, one rising edge
//               later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sh7604_intc_onchip;

  logic        CLK = 1'b0;
  logic        RST_N, CE_R, CE_F, EN, RES_N, INT_ACK;
  logic [10:0] SRC_IRQ;
  logic [7:0]  DMA0_VEC, DMA1_VEC, DIVU_VEC;
  logic [3:0]  INT_LVL;
  logic [7:0]  INT_VEC;
  logic [10:0] INT_ACK_SRC;

  int total = 0;
  int bad   = 0;

  sh7604_intc_onchip_if ibus ();

  sh7604_intc_onchip #(.LOCK_CYC(2)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .CE_R        (CE_R),
    .CE_F        (CE_F),
    .EN          (EN),
    .RES_N       (RES_N),
    .IBUS        (ibus),
    .SRC_IRQ     (SRC_IRQ),
    .DMA0_VEC    (DMA0_VEC),
    .DMA1_VEC    (DMA1_VEC),
    .DIVU_VEC    (DIVU_VEC),
    .INT_ACK     (INT_ACK),
    .INT_LVL     (INT_LVL),
    .INT_VEC     (INT_VEC),
    .INT_ACK_SRC (INT_ACK_SRC)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] ba);
    ibus.A = addr; ibus.DI = data; ibus.BA = ba; ibus.WE = 1'b1; ibus.REQ = 1'b1;
    step();
    ibus.WE = 1'b0; ibus.REQ = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic act);
    ibus.A = addr; ibus.WE = 1'b0; ibus.REQ = 1'b1;
    step();
    d   = ibus.DO;
    act = ibus.ACT;
    ibus.REQ = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        act;
    logic [31:0] addrs [7];
    addrs = '{32'hFFFFFE60, 32'hFFFFFE62, 32'hFFFFFE64, 32'hFFFFFE66,
              32'hFFFFFE68, 32'hFFFFFEE2, 32'hFFFFFEE4};
    total++;
    if (INT_LVL !== 4'd0 || INT_VEC !== 8'd0 || INT_ACK_SRC !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: lvl=%h vec=%h ack=%h required 0/0/0", INT_LVL, INT_VEC, INT_ACK_SRC);
    end
    total++;
    if (ibus.BUSY !== 1'b0) begin
      bad++; $display("FAIL busy_const: got %b required 0", ibus.BUSY);
    end
    RST_N = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      bus_read(addrs[i], d, act);
      total++;
      if (d !== 32'h0 || act !== 1'b1) begin
        bad++; $display("FAIL reset_read[%0d]: do=%h act=%b required 00000000/1", i, d, act);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic        act;
    bus_write(32'hFFFFFE60, 32'h0A00_0000, 4'b1100);
    bus_read(32'hFFFFFE60, d, act);
    total++;
    if (d !== 32'h0A000A00) begin bad++; $display("FAIL iprb_word: got %h required 0a000a00", d); end
    // Byte write into the high byte of VCRA (A[1]=1 lane, BA[1])
    bus_write(32'hFFFFFE62, 32'h0000_4500, 4'b0010);
    bus_read(32'hFFFFFE62, d, act);
    total++;
    if (d !== 32'h45004500) begin bad++; $display("FAIL vcra_byte: got %h required 45004500", d); end
    bus_write(32'hFFFFFEE2, 32'h0000_FFFF, 4'b0011);
    bus_read(32'hFFFFFEE2, d, act);
    total++;
    if (d !== 32'hFFF0FFF0) begin bad++; $display("FAIL ipra_mask: got %h required fff0fff0", d); end
    bus_write(32'hFFFFFEE2, 32'h0000_0000, 4'b0011);
    bus_read(32'hFFFFFE6A, d, act);
    total++;
    if (d !== 32'h0 || act !== 1'b0) begin
      bad++; $display("FAIL unmapped: do=%h act=%b required 00000000/0", d, act);
    end
  endtask

  task automatic test_single();
    bus_write(32'hFFFFFE60, 32'h0500_0000, 4'b1100);
    bus_write(32'hFFFFFE66, 32'h0000_4142, 4'b0011);
    bus_write(32'hFFFFFE68, 32'h4300_0000, 4'b1100);
    SRC_IRQ = 11'h001;
    step();
    total++;
    if (INT_LVL !== 4'd5 || INT_VEC !== 8'h43) begin
      bad++; $display("FAIL single_ovi: lvl=%0d vec=%h required 5/43", INT_LVL, INT_VEC);
    end
  endtask

  task automatic test_tiebreak();
    SRC_IRQ = 11'h007;
    step();
    total++;
    if (INT_LVL !== 4'd5 || INT_VEC !== 8'h41) begin
      bad++; $display("FAIL tie_frt: lvl=%0d vec=%h required 5/41", INT_LVL, INT_VEC);
    end
    bus_write(32'hFFFFFE62, 32'h0000_4522, 4'b0011);
    bus_write(32'hFFFFFE60, 32'h5500_0000, 4'b1100);
    SRC_IRQ = 11'h027;
    step();
    total++;
    if (INT_LVL !== 4'd5 || INT_VEC !== 8'h22) begin
      bad++; $display("FAIL tie_sci_rxi: lvl=%0d vec=%h required 5/22", INT_LVL, INT_VEC);
    end
    SRC_IRQ = 11'h000;
    step();
    total++;
    if (INT_LVL !== 4'd0 || INT_VEC !== 8'h00) begin
      bad++; $display("FAIL drop_to_idle: lvl=%0d vec=%h required 0/00", INT_LVL, INT_VEC);
    end
  endtask

  task automatic test_preempt();
    bus_write(32'hFFFFFEE2, 32'h0000_9030, 4'b0011);
    bus_write(32'hFFFFFEE4, 32'h1100_0000, 4'b1100);
    DIVU_VEC = 8'h70;
    SRC_IRQ  = 11'h080;
    step();
    total++;
    if (INT_LVL !== 4'd3 || INT_VEC !== 8'h11) begin
      bad++; $display("FAIL wdt_pend: lvl=%0d vec=%h required 3/11", INT_LVL, INT_VEC);
    end
    SRC_IRQ = 11'h480;
    step();
    total++;
    if (INT_LVL !== 4'd9 || INT_VEC !== 8'h70) begin
      bad++; $display("FAIL divu_preempt: lvl=%0d vec=%h required 9/70", INT_LVL, INT_VEC);
    end
  endtask

  task automatic test_ack_lock();
    INT_ACK = 1'b1;
    step();
    INT_ACK = 1'b0;
    SRC_IRQ = 11'h000;
    total++;
    if (INT_ACK_SRC !== 11'h400 || INT_LVL !== 4'd9 || INT_VEC !== 8'h70) begin
      bad++; $display("FAIL ack_pulse: ack=%h lvl=%0d vec=%h required 400/9/70", INT_ACK_SRC, INT_LVL, INT_VEC);
    end
    step();
    total++;
    if (INT_ACK_SRC !== 11'h000 || INT_LVL !== 4'd9 || INT_VEC !== 8'h70) begin
      bad++; $display("FAIL lock_hold: ack=%h lvl=%0d vec=%h required 000/9/70", INT_ACK_SRC, INT_LVL, INT_VEC);
    end
    step();
    total++;
    if (INT_LVL !== 4'd0 || INT_VEC !== 8'h00) begin
      bad++; $display("FAIL lock_exit: lvl=%0d vec=%h required 0/00", INT_LVL, INT_VEC);
    end
    INT_ACK = 1'b1;
    step();
    INT_ACK = 1'b0;
    total++;
    if (INT_ACK_SRC !== 11'h000 || INT_LVL !== 4'd0) begin
      bad++; $display("FAIL ack_idle: ack=%h lvl=%0d required 000/0", INT_ACK_SRC, INT_LVL);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [31:0] d;
    logic        act;
    SRC_IRQ = 11'h400;
    step();
    INT_ACK = 1'b1;
    step();
    INT_ACK = 1'b0;
    total++;
    if (INT_LVL !== 4'd9) begin bad++; $display("FAIL enter_lock: lvl=%0d required 9", INT_LVL); end
    RES_N = 1'b0;
    step();
    RES_N = 1'b1;
    total++;
    if (INT_LVL !== 4'd0 || INT_VEC !== 8'h00) begin
      bad++; $display("FAIL resn_lock: lvl=%0d vec=%h required 0/00", INT_LVL, INT_VEC);
    end
    bus_read(32'hFFFFFEE2, d, act);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL resn_ipra: got %h required 00000000", d); end
    total++;
    if (INT_LVL !== 4'd0) begin bad++; $display("FAIL prio_zero: lvl=%0d required 0", INT_LVL); end
  endtask

  task automatic test_en_ce();
    SRC_IRQ = 11'h001;
    bus_write(32'hFFFFFE60, 32'h0500_0000, 4'b1100);
    EN = 1'b0;
    step();
    total++;
    if (INT_LVL !== 4'd0) begin bad++; $display("FAIL en_low: lvl=%0d required 0", INT_LVL); end
    EN   = 1'b1;
    CE_R = 1'b0;
    step();
    total++;
    if (INT_LVL !== 4'd0) begin bad++; $display("FAIL ce_low: lvl=%0d required 0", INT_LVL); end
    CE_R = 1'b1;
    step();
    total++;
    if (INT_LVL !== 4'd5 || INT_VEC !== 8'h00) begin
      bad++; $display("FAIL en_resume: lvl=%0d vec=%h required 5/00", INT_LVL, INT_VEC);
    end
  endtask

  task automatic test_back_to_back();
    // Acknowledge and priority write land on the same edge.
    INT_ACK = 1'b1;
    bus_write(32'hFFFFFE60, 32'h0700_0000, 4'b1100);
    INT_ACK = 1'b0;
    total++;
    if (INT_ACK_SRC !== 11'h001 || INT_LVL !== 4'd5) begin
      bad++; $display("FAIL ack_with_write: ack=%h lvl=%0d required 001/5", INT_ACK_SRC, INT_LVL);
    end
    step();
    step();
    total++;
    if (INT_LVL !== 4'd0) begin bad++; $display("FAIL lock_exit2: lvl=%0d required 0", INT_LVL); end
    step();
    total++;
    if (INT_LVL !== 4'd7) begin bad++; $display("FAIL rearb: lvl=%0d required 7", INT_LVL); end
    bus_write(32'hFFFFFE60, 32'h0000_0000, 4'b1100);
    step();
    total++;
    if (INT_LVL !== 4'd0) begin bad++; $display("FAIL prio_cleared: lvl=%0d required 0", INT_LVL); end
  endtask

  initial begin
    RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b1; EN = 1'b1; RES_N = 1'b1; INT_ACK = 1'b0;
    SRC_IRQ = '0; DMA0_VEC = 8'h50; DMA1_VEC = 8'h51; DIVU_VEC = 8'h00;
    ibus.A = '0; ibus.DI = '0; ibus.BA = '0; ibus.WE = 1'b0; ibus.REQ = 1'b0;
    step();
    step();
    test_reset();
    test_regs();
    test_single();
    test_tiebreak();
    test_preempt();
    test_ack_lock();
    test_reset_mid_lock();
    test_en_ce();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
